// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-RAM arbiter between the CPU memory stage and a DMA master.
package mem_arb_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_t;

   localparam int unsigned BURST_CNT_W               = 4;
   localparam int unsigned MEM_ARB_BURST_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// CPU, DMA and RAM-side bus bundle for mem_arbiter; slave = arbiter, master = requesters and RAM.
interface mem_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);

   logic              CpuReq;
   logic              CpuWe;
   logic [ADDR_W-1:0] CpuAddr;
   logic [DATA_W-1:0] CpuWData;
   logic              CpuStall;
   logic [DATA_W-1:0] CpuRData;
   logic              CpuRValid;

   logic              DmaReq;
   logic              DmaWe;
   logic [ADDR_W-1:0] DmaAddr;
   logic [DATA_W-1:0] DmaWData;
   logic              DmaGnt;
   logic [DATA_W-1:0] DmaRData;
   logic              DmaRValid;

   logic              MemEn;
   logic              MemWe;
   logic [ADDR_W-1:0] MemAddr;
   logic [DATA_W-1:0] MemWData;
   logic [DATA_W-1:0] MemRData;

   modport slave (
      input  CpuReq, CpuWe, CpuAddr, CpuWData,
      output CpuStall, CpuRData, CpuRValid,
      input  DmaReq, DmaWe, DmaAddr, DmaWData,
      output DmaGnt, DmaRData, DmaRValid,
      output MemEn, MemWe, MemAddr, MemWData,
      input  MemRData
   );

   modport master (
      output CpuReq, CpuWe, CpuAddr, CpuWData,
      input  CpuStall, CpuRData, CpuRValid,
      output DmaReq, DmaWe, DmaAddr, DmaWData,
      input  DmaGnt, DmaRData, DmaRValid,
      input  MemEn, MemWe, MemAddr, MemWData,
      output MemRData
   );

endinterface

// File: rtl/mem_arbiter_rr_grant.sv
// Round-robin grant decision with a bounded DMA burst allowance; outputs are one-hot or zero.
module rr_grant
   import mem_arb_pkg::*;
#(
   parameter int unsigned BURST_MAX = MEM_ARB_BURST_MAX_DEFAULT
) (
   input  logic                   cpu_req,
   input  logic                   dma_req,
   input  owner_t                 last_owner,
   input  logic [BURST_CNT_W-1:0] burst_cnt,
   output logic                   cpu_grant,
   output logic                   dma_grant
);

   logic dma_in_burst;

   // A zero count with DMA as last owner means its run was broken by an idle
   // cycle (or reset), so the tie starts fresh and the CPU goes first.
   assign dma_in_burst = (last_owner == OWN_DMA) && (burst_cnt != '0) &&
                         (burst_cnt < BURST_CNT_W'(BURST_MAX));

   always_comb begin
      cpu_grant = 1'b0;
      dma_grant = 1'b0;
      if (cpu_req && dma_req) begin
         if ((last_owner == OWN_CPU) || dma_in_burst) dma_grant = 1'b1;
         else                                         cpu_grant = 1'b1;
      end else begin
         cpu_grant = cpu_req;
         dma_grant = dma_req;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Data-RAM arbiter: CPU vs DMA round-robin, RAM port mux and one-cycle read return.
// Optional performance counters are enabled with `define MEM_ARB_PERF_EN.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned BURST_MAX = MEM_ARB_BURST_MAX_DEFAULT
) (
   input  logic         CLK,
   input  logic         Reset,
   mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
   , output logic [31:0] CpuStallCnt
   , output logic [31:0] DmaBeatCnt
`endif
);

   logic                   cpu_grant, dma_grant;
   owner_t                 last_owner_q, last_owner_d;
   logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
   logic                   cpu_rd_q, cpu_rd_d;
   logic                   dma_rd_q, dma_rd_d;
   logic [ADDR_W-1:0]      mem_addr;
   logic [DATA_W-1:0]      mem_wdata;

   rr_grant #(.BURST_MAX(BURST_MAX)) u_rr_grant (
      .cpu_req    (bus.CpuReq & ~Reset),
      .dma_req    (bus.DmaReq & ~Reset),
      .last_owner (last_owner_q),
      .burst_cnt  (burst_cnt_q),
      .cpu_grant  (cpu_grant),
      .dma_grant  (dma_grant)
   );

   always_comb begin
      last_owner_d = last_owner_q;
      if (cpu_grant)      last_owner_d = OWN_CPU;
      else if (dma_grant) last_owner_d = OWN_DMA;

      burst_cnt_d = '0;
      if (dma_grant)
         burst_cnt_d = (burst_cnt_q >= BURST_CNT_W'(BURST_MAX)) ? burst_cnt_q
                                                                : burst_cnt_q + BURST_CNT_W'(1);

      cpu_rd_d = cpu_grant & ~bus.CpuWe;
      dma_rd_d = dma_grant & ~bus.DmaWe;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         last_owner_q <= OWN_DMA;
         burst_cnt_q  <= '0;
         cpu_rd_q     <= 1'b0;
         dma_rd_q     <= 1'b0;
      end else begin
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         cpu_rd_q     <= cpu_rd_d;
         dma_rd_q     <= dma_rd_d;
      end
   end

   always_comb begin
      bus.MemWe = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (cpu_grant) begin
         bus.MemWe = bus.CpuWe;
         mem_addr  = bus.CpuAddr;
         mem_wdata = bus.CpuWData;
      end else if (dma_grant) begin
         bus.MemWe = bus.DmaWe;
         mem_addr  = bus.DmaAddr;
         mem_wdata = bus.DmaWData;
      end
   end

   assign bus.MemEn    = cpu_grant | dma_grant;
   assign bus.MemAddr  = mem_addr;
   assign bus.MemWData = mem_wdata;
   assign bus.CpuStall = bus.CpuReq & ~cpu_grant;
   assign bus.DmaGnt   = dma_grant;

   // Reset gates the return so a read granted just before reset is dropped.
   assign bus.CpuRValid = cpu_rd_q & ~Reset;
   assign bus.DmaRValid = dma_rd_q & ~Reset;
   assign bus.CpuRData  = bus.CpuRValid ? bus.MemRData : '0;
   assign bus.DmaRData  = bus.DmaRValid ? bus.MemRData : '0;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] beat_cnt_q, beat_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      beat_cnt_d  = beat_cnt_q;
      if (bus.CpuStall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (dma_grant && (beat_cnt_q != '1))     beat_cnt_d  = beat_cnt_q + 32'd1;
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         stall_cnt_q <= '0;
         beat_cnt_q  <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   assign CpuStallCnt = stall_cnt_q;
   assign DmaBeatCnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed cycles push expected read returns, a monitor pops them.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef struct {
      logic        is_dma;
      logic [31:0] data;
   } exp_t;

   logic CLK   = 1'b0;
   logic Reset = 1'b1;
   always #5 CLK = ~CLK;

   mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef MEM_ARB_PERF_EN
   logic [31:0] CpuStallCnt, DmaBeatCnt;
`endif

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(4)) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
`ifdef MEM_ARB_PERF_EN
      , .CpuStallCnt (CpuStallCnt)
      , .DmaBeatCnt  (DmaBeatCnt)
`endif
   );

   logic [31:0] ram     [0:255];
   logic [31:0] ref_mem [0:255];
   exp_t        exp_q[$];
   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;
   bit          mon_en = 1'b0;
   bit          prev_rd = 1'b0;

   // Synchronous single-port RAM: read data appears the cycle after MemEn.
   always @(posedge CLK) begin
      if (bus.MemEn) begin
         if (bus.MemWe) ram[bus.MemAddr[7:0]] <= bus.MemWData;
         else           bus.MemRData <= ram[bus.MemAddr[7:0]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge CLK) begin
      if (mon_en && (bus.CpuRValid || bus.DmaRValid)) begin
         chk("rv_overlap", 64'(bus.CpuRValid & bus.DmaRValid), 0);
         if (exp_q.size() == 0) begin
            chk("rv_unexpected", 64'({bus.CpuRValid, bus.DmaRValid}), 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rv_owner", 64'(bus.DmaRValid), 64'(e.is_dma));
            chk("rv_data", e.is_dma ? 64'(bus.DmaRData) : 64'(bus.CpuRData), 64'(e.data));
            chk("rdata_nonowner", e.is_dma ? 64'(bus.CpuRData) : 64'(bus.DmaRData), 0);
         end
      end
   end

   task automatic step(input bit rst,
                       input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit dr, input bit dw, input logic [31:0] da, input logic [31:0] dd,
                       input bit ec, input bit ed);
      logic [31:0] a;
      Reset        = rst;
      bus.CpuReq   = cr;
      bus.CpuWe    = cw;
      bus.CpuAddr  = ca;
      bus.CpuWData = cd;
      bus.DmaReq   = dr;
      bus.DmaWe    = dw;
      bus.DmaAddr  = da;
      bus.DmaWData = dd;
      @(negedge CLK);
      chk("cpu_stall", 64'(bus.CpuStall), 64'(cr & ~ec));
      chk("dma_gnt",   64'(bus.DmaGnt),   64'(ed));
      chk("mem_en",    64'(bus.MemEn),    64'(ec | ed));
      chk("mem_we",    64'(bus.MemWe),    ec ? 64'(cw) : ed ? 64'(dw) : 64'(0));
      chk("mem_addr",  64'(bus.MemAddr),  ec ? 64'(ca) : ed ? 64'(da) : 64'(0));
      chk("mem_wdata", 64'(bus.MemWData), ec ? 64'(cd) : ed ? 64'(dd) : 64'(0));
      if (rst || !prev_rd) chk("rv_idle", 64'({bus.CpuRValid, bus.DmaRValid}), 0);
      else                 chk("rv_pulse", 64'(bus.CpuRValid | bus.DmaRValid), 1);
      if (rst) exp_q.delete();
      prev_rd = 1'b0;
      if (ec || ed) begin
         a = ec ? ca : da;
         if (ec ? cw : dw) begin
            ref_mem[a[7:0]] = ec ? cd : dd;
         end else begin
            exp_q.push_back('{is_dma: ed, data: ref_mem[a[7:0]]});
            prev_rd = 1'b1;
         end
      end
      @(posedge CLK);
      #1;
   endtask

   initial begin
      logic [31:0] ca, da;
      bit          ec;
      for (int i = 0; i < 256; i++) begin
         ram[i]     = 32'hA500_0000 | 32'(i);
         ref_mem[i] = 32'hA500_0000 | 32'(i);
      end
      ram[8'h10]     = 32'hDEAD_BEEF;
      ref_mem[8'h10] = 32'hDEAD_BEEF;
      @(posedge CLK);
      #1;

      // Reset with CPU requesting: no grant, stall follows request
      step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      mon_en = 1'b1;

      // CPU read of 0x10 returns DEADBEEF next cycle
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // First tie after reset goes to CPU, then DMA
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 32'h14, 0, 1, 0, 32'h18, 0, 1, 0);
      step(0, 1, 0, 32'h1C, 0, 1, 0, 32'h18, 0, 0, 1);
      step(0, 1, 0, 32'h1C, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Sustained contention: CPU, 4xDMA, CPU, 4xDMA, CPU
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      ca = 32'h30;
      da = 32'h40;
      for (int i = 0; i <= 10; i++) begin
         ec = (i == 0) || (i == 5) || (i == 10);
         step(0, 1, 0, ca, 0, i < 10, 0, da, 0, ec, !ec);
         if (ec) ca += 32'd4;
         else    da += 32'd4;
`ifdef MEM_ARB_PERF_EN
         if (i == 9) begin
            chk("cpu_stall_cnt", 64'(CpuStallCnt), 8);
            chk("dma_beat_cnt",  64'(DmaBeatCnt),  8);
         end
`endif
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // DMA write then CPU read-back
      step(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h55, 0, 1);
      step(0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset right after a granted CPU read drops the return
      step(0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 1, 0);
      step(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
